// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    // Receiver frame state
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0]  PS2_EXT_CODE    = 8'hE0;
    localparam logic [7:0]  PS2_BREAK_CODE  = 8'hF0;
    localparam int unsigned PS2_SYNC_STAGES = 2;

    // True when data bits plus parity bit hold an odd number of ones
    function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// CPU-side read/status bus of the PS/2 receiver.
// master = consumer (CPU path), slave = ps2_rx_fifo.
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
) ();
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          clr_ovf;
    logic [7:0]    rd_data;
    logic [1:0]    rd_flags;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overflow;

    modport master (
        output rd_en, clr_ovf,
        input  rd_data, rd_flags, empty, full, count, frame_err, overflow
    );

    modport slave (
        input  rd_en, clr_ovf,
        output rd_data, rd_flags, empty, full, count, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. The head word is held in
// a register so it keeps its last value once the FIFO drains.
module ps2_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       drop
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr, rptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] head_q, head_nxt;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = head_q;

    // Next read pointer, occupancy and head word
    always_comb begin
        rptr_nxt  = do_pop ? rptr + AW'(1) : rptr;
        count_nxt = count;
        unique case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        head_nxt = head_q;
        // The word written this cycle becomes head only when it lands at the new read slot
        if (count_nxt != '0)
            head_nxt = (do_push && (rptr_nxt == wptr)) ? wdata : mem[rptr_nxt];
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    // Pointers, count and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            rptr   <= rptr_nxt;
            count  <= count_nxt;
            head_q <= head_nxt;
        end
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, framing FSM
// with parity/stop checks and frame timeout, feeding a show-ahead FIFO.
// Optional macro PS2_BREAK_DECODE_EN folds E0/F0 prefixes into rd_flags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          inCLK_50MHZ,
    input  logic          BTN_NORTH,
    input  logic          PS2_CLK,
    input  logic          PS2_DATA,
    ps2_rx_fifo_if.slave  bus
);
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_BREAK_DECODE_EN
    localparam int unsigned EW = 10;
`else
    localparam int unsigned EW = 8;
`endif

    logic clk;
    logic rst;
    assign clk = inCLK_50MHZ;
    assign rst = BTN_NORTH;

    logic [PS2_SYNC_STAGES-1:0] clk_sync, data_sync;
    logic          clk_s, data_s;
    logic          filt_clk, fe;
    logic [FW-1:0] filt_cnt;

    ps2_state_e    state, state_nxt;
    logic [2:0]    bitcnt, bitcnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par, par_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          push, err_nxt;
    logic [EW-1:0] push_word;
    logic [EW-1:0] head;
    logic          drop;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          frame_err_q, overflow_q;

`ifdef PS2_BREAK_DECODE_EN
    logic pend_ext, pend_ext_nxt;
    logic pend_brk, pend_brk_nxt;
`endif

    assign clk_s  = clk_sync[PS2_SYNC_STAGES-1];
    assign data_s = data_sync[PS2_SYNC_STAGES-1];

    // Two-stage synchronisers for the raw pins (idle level is high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[PS2_SYNC_STAGES-2:0], PS2_CLK};
            data_sync <= {data_sync[PS2_SYNC_STAGES-2:0], PS2_DATA};
        end
    end

    // Glitch filter: follow the synchronised clock after FILTER_LEN differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                fe       <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            tcnt        <= '0;
            frame_err_q <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
            pend_ext    <= 1'b0;
            pend_brk    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            bitcnt      <= bitcnt_nxt;
            shreg       <= shreg_nxt;
            par         <= par_nxt;
            tcnt        <= tcnt_nxt;
            frame_err_q <= err_nxt;
`ifdef PS2_BREAK_DECODE_EN
            pend_ext    <= pend_ext_nxt;
            pend_brk    <= pend_brk_nxt;
`endif
        end
    end

    // Next-state, timeout and push decision
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        par_nxt    = par;
        push       = 1'b0;
        err_nxt    = 1'b0;
        push_word  = '0;
`ifdef PS2_BREAK_DECODE_EN
        pend_ext_nxt = pend_ext;
        pend_brk_nxt = pend_brk;
`endif
        if (state == IDLE || fe)
            tcnt_nxt = '0;
        else
            tcnt_nxt = tcnt + TW'(1);

        unique case (state)
            IDLE: begin
                if (fe && !data_s) begin
                    state_nxt  = DATA;
                    bitcnt_nxt = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shreg_nxt  = {data_s, shreg[7:1]};
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7)
                        state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (fe) begin
                    par_nxt   = data_s;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_nxt = IDLE;
                    if (data_s && ps2_parity_ok(shreg, par)) begin
`ifdef PS2_BREAK_DECODE_EN
                        if (shreg == PS2_EXT_CODE) begin
                            pend_ext_nxt = 1'b1;
                        end else if (shreg == PS2_BREAK_CODE) begin
                            pend_brk_nxt = 1'b1;
                        end else begin
                            push         = 1'b1;
                            push_word    = {pend_brk, pend_ext, shreg};
                            pend_ext_nxt = 1'b0;
                            pend_brk_nxt = 1'b0;
                        end
`else
                        push      = 1'b1;
                        push_word = shreg;
`endif
                    end else begin
                        err_nxt = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                        pend_ext_nxt = 1'b0;
                        pend_brk_nxt = 1'b0;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort a stalled frame; a falling edge in the same cycle takes priority
        if (state != IDLE && !fe && tcnt == TOUT_MAX) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
            pend_ext_nxt = 1'b0;
            pend_brk_nxt = 1'b0;
`endif
        end
    end

    ps2_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (bus.rd_en),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (drop)
    );

    // Sticky overflow; a drop in the same cycle as clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow_q <= 1'b0;
        else if (drop)
            overflow_q <= 1'b1;
        else if (bus.clr_ovf)
            overflow_q <= 1'b0;
    end

    assign bus.rd_data   = head[7:0];
`ifdef PS2_BREAK_DECODE_EN
    assign bus.rd_flags  = head[9:8];
`else
    assign bus.rd_flags  = 2'b00;
`endif
    assign bus.empty     = fifo_empty;
    assign bus.full      = fifo_full;
    assign bus.count     = fifo_count;
    assign bus.frame_err = frame_err_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo (FIFO_DEPTH=4, FILTER_LEN=4, TIMEOUT_CYCLES=1000,
// PS/2 bit period 200 system clocks). Honours PS2_BREAK_DECODE_EN when defined.
module tb_ps2_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   err_cnt = 0;

    ps2_rx_fifo_if #(.FIFO_DEPTH(4)) bus ();

    ps2_rx_fifo #(
        .FIFO_DEPTH     (4),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .inCLK_50MHZ (clk),
        .BTN_NORTH   (rst),
        .PS2_CLK     (ps2_clk),
        .PS2_DATA    (ps2_data),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Count cycles with frame_err high
    always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

    // One PS/2 bit: data settles, clock low 100, high 100
    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (49) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (100) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    // First half of a bit: returns right after the clock is pulled low
    task automatic ps2_fall(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (49) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_rise();
        repeat (100) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    // Bit with a 2-cycle low glitch while high and a 2-cycle high glitch while low
    task automatic ps2_bit_glitch(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (27) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (40) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (58) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, parity (odd when par_good)
    task automatic send_head(input logic [7:0] d, input logic par_good);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par_good ? ~^d : ^d);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_good, input logic stop);
        send_head(d, par_good);
        ps2_bit(stop);
    endtask

    task automatic pop_one();
        @(negedge clk) bus.rd_en = 1'b1;
        @(negedge clk) bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data got %h want 00", bus.rd_data); end
        n_cmp++; if (bus.rd_flags !== 2'b00) begin n_fail++; $display("FAIL rst_rd_flags got %b want 00", bus.rd_flags); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", bus.full); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err got %b want 0", bus.frame_err); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", bus.overflow); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // 0x1C has three ones, so the odd-parity bit is 0
    task automatic test_good_frame();
        send_head(8'h1C, 1'b1);
        ps2_fall(1'b1);
        // 2 sync stages + 4 filter samples put fe after the 6th edge, push on the 7th
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL lat_empty_at_fe got %b want 1", bus.empty); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL lat_empty_after got %b want 0", bus.empty); end
        n_cmp++; if (bus.rd_data !== 8'h1C) begin n_fail++; $display("FAIL good_rd_data got %h want 1c", bus.rd_data); end
        n_cmp++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL good_count got %0d want 1", bus.count); end
        ps2_rise();
        pop_one();
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL good_pop_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.rd_data !== 8'h1C) begin n_fail++; $display("FAIL good_hold_data got %h want 1c", bus.rd_data); end
    endtask

    task automatic test_bad_frames();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        n_cmp++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL parity_err_pulses got %0d want 1", err_cnt - e0); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL parity_count got %0d want 0", bus.count); end
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        n_cmp++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL stop_err_pulses got %0d want 1", err_cnt - e0); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL stop_count got %0d want 0", bus.count); end
        ps2_data = 1'b1;
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (1100) @(negedge clk);
        n_cmp++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL tout_err_pulses got %0d want 1", err_cnt - e0); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL tout_count got %0d want 0", bus.count); end
        e0 = err_cnt;
        send_frame(8'h29, 1'b1, 1'b1);
        n_cmp++; if (bus.rd_data !== 8'h29) begin n_fail++; $display("FAIL tout_next_data got %h want 29", bus.rd_data); end
        n_cmp++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL tout_next_count got %0d want 1", bus.count); end
        n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL tout_next_err got %0d want 0", err_cnt - e0); end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        n_cmp++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", bus.full); end
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", bus.count); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            n_cmp++; if (bus.rd_data !== exp) begin n_fail++; $display("FAIL ovf_read%0d got %h want %h", i, bus.rd_data, exp); end
            pop_one();
        end
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got %b want 1", bus.empty); end
        // Read while empty is ignored
        pop_one();
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL ovf_empty_pop got %0d want 0", bus.count); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
        @(negedge clk) bus.clr_ovf = 1'b1;
        @(negedge clk) bus.clr_ovf = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end

        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
        send_head(8'h05, 1'b1);
        ps2_fall(1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk) bus.rd_en = 1'b1;
        @(negedge clk) bus.rd_en = 1'b0;
        ps2_rise();
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow got %b want 0", bus.overflow); end
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL pp_count got %0d want 4", bus.count); end
        n_cmp++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL pp_full got %b want 1", bus.full); end
        for (int i = 2; i <= 5; i++) begin
            exp = 8'(i);
            n_cmp++; if (bus.rd_data !== exp) begin n_fail++; $display("FAIL pp_read%0d got %h want %h", i, bus.rd_data, exp); end
            pop_one();
        end
    endtask

    task automatic test_glitch_and_reset();
        int e0;
        logic [7:0] d;
        e0 = err_cnt;
        d = 8'h5A;
        ps2_bit_glitch(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit_glitch(d[i]);
        ps2_bit_glitch(~^d);
        ps2_bit_glitch(1'b1);
        n_cmp++; if (bus.rd_data !== 8'h5A) begin n_fail++; $display("FAIL glitch_data got %h want 5a", bus.rd_data); end
        n_cmp++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL glitch_count got %0d want 1", bus.count); end
        n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL glitch_err got %0d want 0", err_cnt - e0); end
        send_frame(8'h33, 1'b1, 1'b1);
        n_cmp++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL prerst_count got %0d want 2", bus.count); end
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", bus.rd_data); end
        n_cmp++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.frame_err !== 1'b0 || bus.rd_flags !== 2'b00) begin
            n_fail++; $display("FAIL midrst_flags got full=%b ovf=%b ferr=%b flags=%b want 0 0 0 00", bus.full, bus.overflow, bus.frame_err, bus.rd_flags);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        e0 = err_cnt;
        send_frame(8'h6B, 1'b1, 1'b1);
        n_cmp++; if (bus.rd_data !== 8'h6B) begin n_fail++; $display("FAIL postrst_data got %h want 6b", bus.rd_data); end
        n_cmp++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL postrst_count got %0d want 1", bus.count); end
        n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL postrst_err got %0d want 0", err_cnt - e0); end
        pop_one();
    endtask

    task automatic test_break_decode();
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h74, 1'b1, 1'b1);
`ifdef PS2_BREAK_DECODE_EN
        n_cmp++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL brk_count got %0d want 1", bus.count); end
        n_cmp++; if (bus.rd_data !== 8'h74) begin n_fail++; $display("FAIL brk_data got %h want 74", bus.rd_data); end
        n_cmp++; if (bus.rd_flags !== 2'b11) begin n_fail++; $display("FAIL brk_flags got %b want 11", bus.rd_flags); end
        pop_one();
`else
        n_cmp++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL brk_count got %0d want 3", bus.count); end
        n_cmp++; if (bus.rd_data !== 8'hE0) begin n_fail++; $display("FAIL brk_data0 got %h want e0", bus.rd_data); end
        n_cmp++; if (bus.rd_flags !== 2'b00) begin n_fail++; $display("FAIL brk_flags got %b want 00", bus.rd_flags); end
        pop_one();
        n_cmp++; if (bus.rd_data !== 8'hF0) begin n_fail++; $display("FAIL brk_data1 got %h want f0", bus.rd_data); end
        pop_one();
        n_cmp++; if (bus.rd_data !== 8'h74) begin n_fail++; $display("FAIL brk_data2 got %h want 74", bus.rd_data); end
        pop_one();
`endif
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL brk_empty got %b want 1", bus.empty); end
    endtask

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_timeout();
        test_overflow();
        test_glitch_and_reset();
        test_break_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
